// File: rtl/input_feed_ctrl_pkg.sv
// Shared definitions for the input feed controller.
//   CHAR_W       : width of one tape character
//   feed_state_e : controller FSM states (IDLE, FEED, HOLD)
package input_feed_ctrl_pkg;

  localparam int unsigned CHAR_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FEED = 2'd1,
    HOLD = 2'd2
  } feed_state_e;

endpackage

// File: rtl/feed_fifo.sv
// Character FIFO between the tape reader and the feed controller.
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   push, wr_data      : write request and character (ignored while full)
//   pop                : read request (ignored while empty)
//   rd_data            : current head character
//   full, empty, level : occupancy status, all derived from registered state
module feed_fifo
  import input_feed_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [CHAR_W-1:0]        wr_data,
  input  logic                     pop,
  output logic [CHAR_W-1:0]        rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = PtrW + 1;

  logic [CHAR_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]   level_q;
  logic              push_ok, pop_ok;

  // Level is one bit wider than the pointers so full and empty stay distinct.
  assign full    = (level_q == LvlW'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rd_data = mem_q[rd_ptr_q];

  // A push at full is dropped even if a pop frees a slot in the same cycle.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push_ok && !pop_ok) begin
        level_q <= level_q + LvlW'(1);
      end else if (pop_ok && !push_ok) begin
        level_q <= level_q - LvlW'(1);
      end
    end
  end

  // Storage needs no reset; head data is masked by the controller when invalid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/input_feed_ctrl.sv
// Input feed controller: buffers tape characters in a FIFO and feeds them
// to the processor under start/stop control, one character per start or
// continuously depending on sw_continuous_input.
// Ports:
//   clk, reset                      : clock, synchronous active-high reset
//   tape_val/tape_data/tape_rdy     : tape-side valid/ready character input
//   btn_start_input, btn_stop_input : one-cycle start/stop requests
//   sw_continuous_input             : 1 = continuous feed, 0 = single char
//   dev_input_val/rdy/data          : processor-side valid/ready output
//   feed_busy                       : controller not idle
//   fifo_level                      : FIFO occupancy
//   feed_count                      : transfer counter, only when the
//                                     INPUT_FEED_COUNT_EN macro is defined
module input_feed_ctrl
  import input_feed_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   tape_val,
  input  logic [CHAR_W-1:0]      tape_data,
  output logic                   tape_rdy,
  input  logic                   btn_start_input,
  input  logic                   btn_stop_input,
  input  logic                   sw_continuous_input,
  input  logic                   dev_input_rdy,
  output logic                   dev_input_val,
  output logic [CHAR_W-1:0]      dev_input_data,
  output logic                   feed_busy,
  output logic [$clog2(DEPTH):0] fifo_level
`ifdef INPUT_FEED_COUNT_EN
  ,
  output logic [15:0]            feed_count
`endif
);

  feed_state_e       state_q, state_d;
  logic              fifo_full, fifo_empty;
  logic [CHAR_W-1:0] fifo_head;
  logic              transfer;
  logic              start_ok;

  feed_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (tape_val),
    .wr_data (tape_data),
    .pop     (transfer),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign tape_rdy  = !fifo_full;
  assign feed_busy = (state_q != IDLE);

  // HOLD is only entered with a character presented and nothing pops it except
  // a transfer, so val/data stay stable until accepted.
  assign dev_input_val  = (state_q != IDLE) && !fifo_empty;
  assign dev_input_data = dev_input_val ? fifo_head : '0;
  assign transfer       = dev_input_val && dev_input_rdy;

  // Stop has priority over a simultaneous start.
  assign start_ok = (state_q == IDLE) && btn_start_input && !btn_stop_input;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start_ok) state_d = FEED;
      end
      FEED: begin
        if (transfer) begin
          // Mode is sampled at every transfer, not latched at start.
          if (!sw_continuous_input || btn_stop_input) state_d = IDLE;
        end else if (btn_stop_input) begin
          state_d = dev_input_val ? HOLD : IDLE;
        end
      end
      HOLD: begin
        if (transfer) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef INPUT_FEED_COUNT_EN
  logic [15:0] count_q;

  always_ff @(posedge clk) begin
    if (reset || start_ok) begin
      count_q <= '0;
    end else if (transfer) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign feed_count = count_q;
`endif

endmodule

// File: tb/tb_input_feed_ctrl.sv
// Directed self-checking bench for input_feed_ctrl (DEPTH = 8).
module tb_input_feed_ctrl;
  import input_feed_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        tape_val;
  logic [4:0]  tape_data;
  logic        tape_rdy;
  logic        btn_start_input;
  logic        btn_stop_input;
  logic        sw_continuous_input;
  logic        dev_input_rdy;
  logic        dev_input_val;
  logic [4:0]  dev_input_data;
  logic        feed_busy;
  logic [3:0]  fifo_level;
`ifdef INPUT_FEED_COUNT_EN
  logic [15:0] feed_count;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  input_feed_ctrl #(
    .DEPTH (8)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .tape_val            (tape_val),
    .tape_data           (tape_data),
    .tape_rdy            (tape_rdy),
    .btn_start_input     (btn_start_input),
    .btn_stop_input      (btn_stop_input),
    .sw_continuous_input (sw_continuous_input),
    .dev_input_rdy       (dev_input_rdy),
    .dev_input_val       (dev_input_val),
    .dev_input_data      (dev_input_data),
    .feed_busy           (feed_busy),
    .fifo_level          (fifo_level)
`ifdef INPUT_FEED_COUNT_EN
    ,
    .feed_count          (feed_count)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    tape_val = 1'b0;
    tape_data = '0;
    btn_start_input = 1'b0;
    btn_stop_input = 1'b0;
    sw_continuous_input = 1'b0;
    dev_input_rdy = 1'b0;
    tick();
    tick();
    chk("rst_val", 32'(dev_input_val), 32'd0);
    chk("rst_data", 32'(dev_input_data), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_busy", 32'(feed_busy), 32'd0);
    chk("rst_state", 32'(dut.state_q), 32'(IDLE));
    reset = 1'b0;
    tick();
    chk("rst_tape_rdy", 32'(tape_rdy), 32'd1);

    // Single mode: push 0x03, 0x11; one transfer of 0x03 then IDLE.
    tape_val = 1'b1; tape_data = 5'h03; tick();
    tape_data = 5'h11; tick();
    tape_val = 1'b0;
    chk("single_level2", 32'(fifo_level), 32'd2);
    chk("idle_val0", 32'(dev_input_val), 32'd0);
    btn_start_input = 1'b1; tick(); btn_start_input = 1'b0;
    chk("single_val", 32'(dev_input_val), 32'd1);
    chk("single_data", 32'(dev_input_data), 32'h03);
    dev_input_rdy = 1'b1; tick(); dev_input_rdy = 1'b0;
    chk("single_state", 32'(dut.state_q), 32'(IDLE));
    chk("single_level1", 32'(fifo_level), 32'd1);
    chk("single_val_after", 32'(dev_input_val), 32'd0);
    tick();
    chk("single_no_second", 32'(fifo_level), 32'd1);

    // Drain 0x11 in continuous mode, leaving FEED with an empty FIFO.
    btn_start_input = 1'b1; tick(); btn_start_input = 1'b0;
    chk("drain_data", 32'(dev_input_data), 32'h11);
    sw_continuous_input = 1'b1; dev_input_rdy = 1'b1; tick(); dev_input_rdy = 1'b0;
    chk("feed_empty_val", 32'(dev_input_val), 32'd0);
    chk("feed_empty_busy", 32'(feed_busy), 32'd1);

    // Push into empty FIFO while feeding: valid the cycle after the push.
    tape_val = 1'b1; tape_data = 5'h0A; tick(); tape_val = 1'b0;
    chk("push_lat_val", 32'(dev_input_val), 32'd1);
    chk("push_lat_data", 32'(dev_input_data), 32'h0A);
    btn_stop_input = 1'b1; tick(); btn_stop_input = 1'b0;
    chk("stop_hold", 32'(dut.state_q), 32'(HOLD));
    btn_start_input = 1'b1; tick(); btn_start_input = 1'b0;
    chk("hold_ign_start", 32'(dut.state_q), 32'(HOLD));
    chk("hold_data", 32'(dev_input_data), 32'h0A);
    dev_input_rdy = 1'b1; tick(); dev_input_rdy = 1'b0;
    chk("hold_xfer_idle", 32'(dut.state_q), 32'(IDLE));
    chk("hold_xfer_level", 32'(fifo_level), 32'd0);

    // Continuous: fill with 0x00..0x07, then stream them out back to back.
    for (int i = 0; i < 8; i++) begin
      tape_val = 1'b1; tape_data = 5'(i); tick();
    end
    tape_val = 1'b0;
    chk("full_tape_rdy", 32'(tape_rdy), 32'd0);
    chk("full_level", 32'(fifo_level), 32'd8);
    btn_start_input = 1'b1; tick(); btn_start_input = 1'b0;
    dev_input_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("cont_val", 32'(dev_input_val), 32'd1);
      chk("cont_data", 32'(dev_input_data), 32'(i));
      tick();
    end
    dev_input_rdy = 1'b0;
    chk("cont_end_val", 32'(dev_input_val), 32'd0);
    chk("cont_end_level", 32'(fifo_level), 32'd0);
    btn_stop_input = 1'b1; tick(); btn_stop_input = 1'b0;
    chk("stop_empty_idle", 32'(dut.state_q), 32'(IDLE));

    // Start and stop together from IDLE: stop wins.
    tape_val = 1'b1; tape_data = 5'h02; tick(); tape_val = 1'b0;
    btn_start_input = 1'b1; btn_stop_input = 1'b1; tick();
    btn_start_input = 1'b0; btn_stop_input = 1'b0;
    chk("startstop_state", 32'(dut.state_q), 32'(IDLE));
    chk("startstop_val", 32'(dev_input_val), 32'd0);

    // Refill to full behind 0x02 with 0x11..0x17.
    for (int i = 0; i < 7; i++) begin
      tape_val = 1'b1; tape_data = 5'(5'h11 + i); tick();
    end
    tape_val = 1'b0;
    chk("refill_level", 32'(fifo_level), 32'd8);
    btn_start_input = 1'b1; tick(); btn_start_input = 1'b0;
    // Full with pop and push together: pop happens, push rejected.
    dev_input_rdy = 1'b1; tape_val = 1'b1; tape_data = 5'h1F;
    chk("fullpp_head", 32'(dev_input_data), 32'h02);
    tick();
    dev_input_rdy = 1'b0;
    chk("fullpp_level", 32'(fifo_level), 32'd7);
    chk("fullpp_tape_rdy", 32'(tape_rdy), 32'd1);
    tick(); tape_val = 1'b0;
    chk("fullpp_push_next", 32'(fifo_level), 32'd8);
    dev_input_rdy = 1'b1;
    for (int i = 0; i < 7; i++) begin
      chk("order_data", 32'(dev_input_data), 32'(5'h11 + i));
      tick();
    end
    dev_input_rdy = 1'b0;

    // Backpressure on 0x1F with stop in the middle -> HOLD, then one transfer.
    for (int c = 0; c < 5; c++) begin
      btn_stop_input = (c == 2);
      tick();
      chk("bp_val", 32'(dev_input_val), 32'd1);
      chk("bp_data", 32'(dev_input_data), 32'h1F);
    end
    btn_stop_input = 1'b0;
    chk("bp_hold", 32'(dut.state_q), 32'(HOLD));
    dev_input_rdy = 1'b1; tick(); dev_input_rdy = 1'b0;
    chk("bp_idle", 32'(dut.state_q), 32'(IDLE));
    chk("bp_level", 32'(fifo_level), 32'd0);

    // Mode is sampled at each transfer.
    tape_val = 1'b1; tape_data = 5'h05; tick();
    tape_data = 5'h06; tick(); tape_val = 1'b0;
    sw_continuous_input = 1'b0;
    btn_start_input = 1'b1; tick(); btn_start_input = 1'b0;
    sw_continuous_input = 1'b1; dev_input_rdy = 1'b1; tick();
    chk("mode_cont_busy", 32'(feed_busy), 32'd1);
    chk("mode_cont_data", 32'(dev_input_data), 32'h06);
    sw_continuous_input = 1'b0; tick(); dev_input_rdy = 1'b0;
    chk("mode_single_idle", 32'(dut.state_q), 32'(IDLE));
    chk("mode_level", 32'(fifo_level), 32'd0);

`ifdef INPUT_FEED_COUNT_EN
    // 65537 continuous transfers wrap the counter to 1.
    sw_continuous_input = 1'b1; dev_input_rdy = 1'b1;
    tape_val = 1'b1; tape_data = 5'h01;
    btn_start_input = 1'b1; tick(); btn_start_input = 1'b0;
    chk("cnt_cleared", 32'(feed_count), 32'd0);
    for (int k = 0; k < 65537; k++) tick();
    chk("cnt_wrap", 32'(feed_count), 32'd1);
    chk("cnt_level", 32'(fifo_level), 32'd1);
    reset = 1'b1; tick(); reset = 1'b0;
    tape_val = 1'b0; dev_input_rdy = 1'b0;
    chk("cnt_rst", 32'(feed_count), 32'd0);
`endif

    // Reset mid-transfer discards everything.
    tape_val = 1'b1; tape_data = 5'h07; tick(); tape_val = 1'b0;
    btn_start_input = 1'b1; tick(); btn_start_input = 1'b0;
    chk("midrst_pre_val", 32'(dev_input_val), 32'd1);
    dev_input_rdy = 1'b1; reset = 1'b1; tick();
    reset = 1'b0; dev_input_rdy = 1'b0;
    chk("midrst_val", 32'(dev_input_val), 32'd0);
    chk("midrst_level", 32'(fifo_level), 32'd0);
    chk("midrst_busy", 32'(feed_busy), 32'd0);
    chk("midrst_data", 32'(dev_input_data), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/input_feed_ctrl.md
INPUT_FEED_CTRL -- requirements
Module: input_feed_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning FIFO entries (power of two, 2..32).
REQ-002 SHALL have port clk  in  1  sole clock, rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port tape_val  in  1  tape side offers a 5-bit character.
REQ-005 SHALL have port tape_data  in  5  character offered.
REQ-006 SHALL have port tape_rdy  out  1  FIFO can accept a character.
REQ-007 SHALL have port btn_start_input  in  1  one-cycle start request.
REQ-008 SHALL have port btn_stop_input  in  1  one-cycle stop request.
REQ-009 SHALL have port sw_continuous_input  in  1  1 = continuous feed; 0 = single character per start.
REQ-010 SHALL have port dev_input_rdy  in  1  processor accepts a character.
REQ-011 SHALL have port dev_input_val  out  1  character valid toward processor.
REQ-012 SHALL have port dev_input_data  out  5  character toward processor.
REQ-013 SHALL have port feed_busy  out  1  state is not IDLE.
REQ-014 SHALL have port fifo_level  out  $clog2(DEPTH)+1  current occupancy.

Function
REQ-015 SHALL push tape_data when tape_val && tape_rdy; tape_rdy = !full, from registered state only.
REQ-016 SHALL reject a push at full even if a pop occurs in the same cycle.
REQ-017 SHALL allow simultaneous push and pop when neither full nor empty; level unchanged.
REQ-018 SHALL use an FSM with states IDLE, FEED, HOLD.
REQ-019 IDLE: dev_input_val=0; btn_start_input -> FEED.
REQ-020 FEED: dev_input_val = !empty; dev_input_data = FIFO head; empty -> stay FEED with val=0.
REQ-021 SHALL drive a character pushed into an empty FIFO on dev_input_val exactly one cycle after the push.
REQ-022 A transfer (val && rdy) pops the head; in single mode the FSM then -> IDLE; in continuous mode it stays FEED.
REQ-023 Once dev_input_val is high, it and dev_input_data SHALL stay stable until transfer (no withdrawal).
REQ-024 btn_stop_input in FEED with val=0 -> IDLE next cycle; with val=1 and no transfer that cycle -> HOLD.
REQ-025 HOLD: keep val/data stable; on transfer -> IDLE; further start/stop ignored.
REQ-026 btn_start_input and btn_stop_input in the same cycle: stop wins (start ignored).
REQ-027 btn_start_input outside IDLE SHALL be ignored.
REQ-028 sw_continuous_input SHALL be sampled at each transfer, not latched at start.
REQ-029 FIFO pointers SHALL wrap modulo DEPTH; level SHALL distinguish full from empty.

Reset
REQ-030 On reset: state IDLE, FIFO empty, fifo_level=0, tape_rdy=1 (first cycle after reset release), dev_input_val=0, dev_input_data=0, feed_busy=0.
REQ-031 Reset mid-transfer SHALL discard FIFO contents and any pending character; no transfer completes.

Configuration
REQ-032 Macro INPUT_FEED_COUNT_EN defined: SHALL add output feed_count out 16, incremented per transfer, wrapping 0xFFFF->0, cleared by reset and by btn_start_input accepted in IDLE.
REQ-033 Macro undefined: port feed_count and counter logic SHALL be absent; all other behaviour identical.

Structure
REQ-034 Shared package SHALL hold the FSM state enum (IDLE, FEED, HOLD) and CHAR_W=5.
REQ-035 FIFO SHALL be one sub-module feed_fifo (push/pop/full/empty/level); FSM stays in input_feed_ctrl.

Verification
REQ-036 Single mode: push 0x03,0x11; start; rdy=1 -> exactly one transfer 0x03, state IDLE, level=1.
REQ-037 Continuous: push 8 characters 0x00..0x07 with DEPTH=8 -> tape_rdy=0 at full; start, rdy=1 -> 0x00..0x07 in order on consecutive cycles, then val=0.
REQ-038 Backpressure: FEED, val=1 data=0x1F, rdy=0 for 5 cycles, stop pulsed at cycle 2 -> state HOLD, data held 0x1F; rdy=1 -> one transfer then IDLE.
REQ-039 Start and stop in same cycle from IDLE -> state stays IDLE, val=0.
REQ-040 Full FIFO, rdy=1 and tape_val=1 same cycle -> pop occurs, push rejected, level 7; next cycle push accepted.
REQ-041 With INPUT_FEED_COUNT_EN: 65537 continuous transfers -> feed_count=1; reset mid-FEED -> val=0, level=0, feed_count=0.
